// File: rtl/a2d_scan_ctrl.sv
// Round-robin A2D scan controller: two SPI transactions per conversion (command, readback),
// optional 2**AVG_LOG2 oversample averaging, results kept in a packed per-slot register bank.

module SPI_mnrch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done,
    output logic [15:0] rd_data
);

    logic [15:0] shft_reg;
    logic [2:0]  div;
    logic [3:0]  bit_cnt;
    logic        active;
    logic        miso_smpl;

    // SCLK period is 8 clks: MISO sampled just before the rising edge, shift on the falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shft_reg  <= '0;
            div       <= '0;
            bit_cnt   <= '0;
            active    <= 1'b0;
            miso_smpl <= 1'b0;
            SS_n      <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wrt) begin
                shft_reg <= wt_data;
                div      <= '0;
                bit_cnt  <= '0;
                active   <= 1'b1;
                SS_n     <= 1'b0;
            end else if (active) begin
                div <= div + 3'd1;
                if (div == 3'd3)
                    miso_smpl <= MISO;
                if (div == 3'd7) begin
                    shft_reg <= {shft_reg[14:0], miso_smpl};
                    bit_cnt  <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        active <= 1'b0;
                        SS_n   <= 1'b1;
                        done   <= 1'b1;
                    end
                end
            end
        end
    end

    assign SCLK    = active & div[2];
    assign MOSI    = shft_reg[15];
    assign rd_data = shft_reg;

endmodule

module a2d_scan_ctrl #(
    parameter int unsigned         NUM_CH   = 4,
    parameter logic [3*NUM_CH-1:0] CH_MAP   = {3'd6, 3'd5, 3'd4, 3'd0},
    parameter int unsigned         AVG_LOG2 = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  nxt,
    input  logic                  free_run,
    input  logic                  MISO,
    output logic                  SS_n,
    output logic                  SCLK,
    output logic                  MOSI,
    output logic [12*NUM_CH-1:0]  ch_data,
    output logic                  upd,
    output logic [2:0]            upd_ch,
    output logic                  scan_done
);

    localparam int unsigned AW        = 12 + AVG_LOG2;
    localparam logic [2:0]  AVG_LAST  = 3'((1 << AVG_LOG2) - 1);
    localparam logic [2:0]  LAST_SLOT = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, CMD_WT, GAP, RD, RD_WT, ACC} state_t;

    state_t          state, nxt_state;
    logic            wrt;
    logic            done;
    logic [15:0]     wt_data;
    logic [15:0]     rd_data;
    logic [2:0]      slot;
    logic [2:0]      avg_cnt;
    logic [AW-1:0]   accum;
    logic [AW-1:0]   sum;
    logic [11:0]     avg;
    logic [2:0]      ch_code;
    logic            unused_rd_hi;

    SPI_mnrch u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .wt_data (wt_data),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .done    (done),
        .rd_data (rd_data)
    );

    assign ch_code      = CH_MAP[3*slot +: 3];
    assign wt_data      = {2'b00, ch_code, 11'h000};
    assign sum          = accum + AW'(rd_data[11:0]);
    assign avg          = 12'(sum >> AVG_LOG2);
    assign unused_rd_hi = ^rd_data[15:12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        wrt       = 1'b0;
        case (state)
            IDLE: if (nxt | free_run) begin
                wrt       = 1'b1;
                nxt_state = CMD_WT;
            end
            CMD_WT: if (done) nxt_state = GAP;
            GAP:    nxt_state = RD;
            RD: begin
                wrt       = 1'b1;
                nxt_state = RD_WT;
            end
            RD_WT:  if (done) nxt_state = ACC;
            ACC: if (free_run) begin
                wrt       = 1'b1;
                nxt_state = CMD_WT;
            end else begin
                nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Accumulate/update is committed on the RD_WT->ACC edge so upd is visible during ACC and
    // the slot has already advanced when ACC issues a free-running command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_data   <= '0;
            upd       <= 1'b0;
            upd_ch    <= '0;
            scan_done <= 1'b0;
            slot      <= '0;
            avg_cnt   <= '0;
            accum     <= '0;
        end else begin
            upd       <= 1'b0;
            scan_done <= 1'b0;
            if (state == RD_WT && done) begin
                if (avg_cnt == AVG_LAST) begin
                    ch_data[12*slot +: 12] <= avg;
                    upd       <= 1'b1;
                    upd_ch    <= slot;
                    scan_done <= (slot == LAST_SLOT);
                    accum     <= '0;
                    avg_cnt   <= '0;
                    slot      <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
                end else begin
                    accum   <= sum;
                    avg_cnt <= avg_cnt + 3'd1;
                end
            end
        end
    end

endmodule
